// File: rtl/jtframe_status_load.sv
// Writer side of the OSD status word: assembles a 64-bit shadow from the command
// byte stream, commits it at end of frame and applies hotkey bit toggles.
module jtframe_status_load #(
  parameter logic [7:0]  CMD_STATUS  = 8'h1E,
  parameter logic [7:0]  CMD_STATUS8 = 8'h15,
  parameter logic [63:0] RST_STATUS  = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frm_start,
  input  logic        frm_end,
  input  logic        byte_stb,
  input  logic [7:0]  byte_in,
  input  logic        tgl_stb,
  input  logic [5:0]  tgl_idx,
  output logic [63:0] status,
  output logic        status_upd,
  output logic        status_chg,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    DATA = 3'd2,
    FULL = 3'd3,
    SKIP = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [63:0]        shadow, shadow_nx;
  logic [63:0]        status_nx;
  logic [63:0]        tgl_mask;
  logic [CNT_W-1:0]   count, count_nx;
  logic [CNT_W-1:0]   limit, limit_nx;
  logic               commit;

  // State, shadow and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= RST_STATUS;
      count      <= '0;
      limit      <= '0;
      status     <= RST_STATUS;
      status_upd <= 1'b0;
      status_chg <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      shadow     <= shadow_nx;
      count      <= count_nx;
      limit      <= limit_nx;
      status     <= status_nx;
      status_upd <= commit;
      status_chg <= (status_nx != status);
      busy       <= (state_nx != IDLE);
    end
  end

  // Frame decoding, byte capture, commit and toggle
  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    count_nx  = count;
    limit_nx  = limit;
    commit    = 1'b0;
    tgl_mask  = tgl_stb ? (64'(1) << tgl_idx) : 64'd0;

    case (state)
      CMD: begin
        if (byte_stb) begin
          if (byte_in == CMD_STATUS) begin
            state_nx = DATA;
            limit_nx = CNT_W'(8);
          end else if (byte_in == CMD_STATUS8) begin
            state_nx = DATA;
            limit_nx = CNT_W'(1);
          end else begin
            state_nx = SKIP;
          end
        end
      end
      DATA: begin
        if (byte_stb) begin
          shadow_nx[{count[2:0], 3'b000} +: 8] = byte_in;
          count_nx = count + CNT_W'(1);
          if (count_nx == limit) state_nx = FULL;
        end
      end
      default: ;
    endcase

    // A byte arriving with frm_end is already in shadow_nx/count_nx here
    if (frm_end && state != IDLE) begin
      commit   = ((state == DATA) || (state == FULL)) && (count_nx != '0);
      state_nx = IDLE;
    end

    status_nx = (commit ? shadow_nx : status) ^ tgl_mask;

    if (frm_start) begin
      state_nx  = CMD;
      count_nx  = '0;
      shadow_nx = status_nx;
    end else begin
      shadow_nx = shadow_nx ^ tgl_mask;
    end
  end

endmodule

// File: tb/tb_jtframe_status_load.sv
// Randomized self-checking bench for jtframe_status_load against a frame-level model.
module tb_jtframe_status_load;

  logic        clk = 1'b0;
  logic        rst, frm_start, frm_end, byte_stb, tgl_stb;
  logic [7:0]  byte_in;
  logic [5:0]  tgl_idx;
  logic [63:0] status;
  logic        status_upd, status_chg, busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame contents tracked as a byte array plus accept limit
  logic [63:0] m_status;
  logic [7:0]  m_sb [8];
  bit          m_open, m_cmd_seen, m_upd, m_chg;
  int          m_lim, m_n;

  jtframe_status_load dut (
    .clk(clk), .rst(rst), .frm_start(frm_start), .frm_end(frm_end),
    .byte_stb(byte_stb), .byte_in(byte_in), .tgl_stb(tgl_stb), .tgl_idx(tgl_idx),
    .status(status), .status_upd(status_upd), .status_chg(status_chg), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sb_word();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = m_sb[i];
    return w;
  endfunction

  task automatic sb_load(input logic [63:0] w);
    for (int i = 0; i < 8; i++) m_sb[i] = w[8*i +: 8];
  endtask

  task automatic model_reset();
    m_status = 64'd0; m_open = 0; m_cmd_seen = 0; m_lim = 0; m_n = 0;
    m_upd = 0; m_chg = 0;
    sb_load(64'd0);
  endtask

  task automatic model_step(input bit fs, input bit fe, input bit bs, input logic [7:0] b,
                            input bit ts, input logic [5:0] ti);
    logic [63:0] mask, nxt;
    bit commit;
    mask = ts ? (64'd1 << ti) : 64'd0;
    commit = 0;
    if (m_open) begin
      if (bs) begin
        if (!m_cmd_seen) begin
          m_cmd_seen = 1;
          m_lim = (b == 8'h1E) ? 8 : (b == 8'h15) ? 1 : 0;
        end else if (m_n < m_lim) begin
          m_sb[m_n] = b;
          m_n++;
        end
      end
      if (fe) begin
        commit = (m_n > 0);
        m_open = 0;
      end
    end
    nxt = (commit ? sb_word() : m_status) ^ mask;
    if (fs) begin
      m_open = 1; m_cmd_seen = 0; m_n = 0; m_lim = 0;
      sb_load(nxt);
    end else begin
      sb_load(sb_word() ^ mask);
    end
    m_chg = (nxt != m_status);
    m_upd = commit;
    m_status = nxt;
  endtask

  task automatic check_outputs();
    chk("status", status, m_status);
    chk("status_upd", 64'(status_upd), 64'(m_upd));
    chk("status_chg", 64'(status_chg), 64'(m_chg));
    chk("busy", 64'(busy), 64'(m_open));
  endtask

  task automatic cyc(input bit fs, input bit fe, input bit bs, input logic [7:0] b,
                     input bit ts, input logic [5:0] ti);
    rst = 0; frm_start = fs; frm_end = fe; byte_stb = bs; byte_in = b;
    tgl_stb = ts; tgl_idx = ti;
    model_step(fs, fe, bs, b, ts, ti);
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic do_rst();
    rst = 1; frm_start = 0; frm_end = 0; byte_stb = 0; byte_in = 0; tgl_stb = 0; tgl_idx = 0;
    model_reset();
    @(posedge clk); #1;
    check_outputs();
    rst = 0;
  endtask

  task automatic put(input logic [7:0] b);
    cyc(0, 0, 1, b, 0, 0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    rst = 1; frm_start = 0; frm_end = 0; byte_stb = 0; byte_in = 0; tgl_stb = 0; tgl_idx = 0;
    @(posedge clk); #1;
    do_rst();
    chk("reset_status", status, 64'd0);

    // Full 8-byte write
    cyc(1, 0, 0, 0, 0, 0); put(8'h1E);
    for (int i = 1; i <= 8; i++) put(8'(i));
    cyc(0, 1, 0, 0, 0, 0);
    chk("full_write", status, 64'h0807060504030201);
    chk("full_upd", 64'(status_upd), 64'd1);
    idle();
    chk("upd_one_cycle", 64'(status_upd), 64'd0);

    // All ones, then partial write of byte 0
    cyc(1, 0, 0, 0, 0, 0); put(8'h1E);
    for (int i = 0; i < 8; i++) put(8'hFF);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0); put(8'h1E); put(8'h00); cyc(0, 1, 0, 0, 0, 0);
    chk("partial_write", status, 64'hFFFF_FFFF_FFFF_FF00);

    // Legacy 8-bit command
    cyc(1, 0, 0, 0, 0, 0); put(8'h15); put(8'hAA); put(8'hBB); cyc(0, 1, 0, 0, 0, 0);
    chk("legacy_cmd", status, 64'hFFFF_FFFF_FFFF_FFAA);

    // Nine bytes: ninth ignored, last byte lands with frm_end
    cyc(1, 0, 0, 0, 0, 0); put(8'h1E);
    for (int i = 0; i < 8; i++) put(8'h11 + 8'(i));
    cyc(0, 1, 1, 8'h99, 0, 0);
    chk("ninth_ignored", status, 64'h1817_1615_1413_1211);

    // Unknown command and empty frame
    cyc(1, 0, 0, 0, 0, 0); put(8'h20); put(8'h55); put(8'h66); cyc(0, 1, 0, 0, 0, 0);
    chk("skip_no_upd", 64'(status_upd), 64'd0);
    chk("skip_status", status, 64'h1817_1615_1413_1211);
    cyc(1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
    chk("empty_no_upd", 64'(status_upd), 64'd0);

    // Toggle coincident with commit of zero
    do_rst();
    cyc(1, 0, 0, 0, 0, 0); put(8'h1E);
    for (int i = 0; i < 8; i++) put(8'h00);
    cyc(0, 1, 0, 0, 1, 6'd12);
    chk("tgl_on_commit", status, 64'h1000);

    // Toggle mid-frame survives a byte-0-only commit
    do_rst();
    cyc(1, 0, 0, 0, 0, 0); put(8'h1E);
    cyc(0, 0, 0, 0, 1, 6'd12);
    put(8'h55); cyc(0, 1, 0, 0, 0, 0);
    chk("tgl_mid_frame", status, 64'h1055);

    // Reset mid-frame discards the frame
    cyc(1, 0, 0, 0, 0, 0); put(8'h1E); put(8'h01);
    do_rst();
    chk("rst_busy", 64'(busy), 64'd0);
    put(8'h77); cyc(0, 1, 0, 0, 0, 0);
    chk("rst_no_commit", 64'(status_upd), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit fs, fe, bs, ts;
      logic [7:0] b;
      int sel;
      if ($urandom_range(0, 199) == 0) begin
        do_rst();
      end else begin
        fs  = ($urandom_range(0, 11) == 0);
        fe  = ($urandom_range(0, 9) == 0);
        bs  = ($urandom_range(0, 2) == 0) && !fs;
        ts  = ($urandom_range(0, 15) == 0) && !bs;
        sel = $urandom_range(0, 5);
        b   = (sel == 0) ? 8'h1E : (sel == 1) ? 8'h15 : (sel == 2) ? 8'h20 : 8'($urandom);
        cyc(fs, fe, bs, b, ts, 6'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
